box_moment_acc: RTL and testbench
=================================

Name: box_moment_acc

Overview:
Downstream consumer of the square-grid generator's box-count memory in the multifractal analysis (MFA) pipeline. For one requested grid level, it scans every box count of that level, one read per cycle. It accumulates the first moment (sum n), the second moment (sum n^2) and the occupied-box count (n != 0). It then returns the three results to the partition-function/controller stage through a valid/ready handshake.

Parameters:
BOX_IDX, 3, log2 of finest grid side; address width is 2*BOX_IDX+1
DATA_LEN, 8, width of one box count read from BC memory
S1_LEN, DATA_LEN+2*BOX_IDX, width of sum1 (overflow-free by construction)
S2_LEN, 2*DATA_LEN+2*BOX_IDX, width of sum2 (overflow-free by construction)

Ports:
CLK  in  1  clock
RST  in  1  reset
start  in  1  request a scan of level `level`; accepted only when idle or on result-handshake cycle
level  in  BOX_IDX  grid level; side = 2^(BOX_IDX-level); values > BOX_IDX-1 clamp to BOX_IDX-1
rd_addr  out  2*BOX_IDX+1  BC memory read address {x[BOX_IDX-1:0], bank, y[BOX_IDX-1:0]}
rd_data  in  DATA_LEN  BC memory read data, valid one cycle after rd_addr (synchronous RAM)
busy  out  1  high from accepted start until res_valid
res_valid  out  1  results valid, held until res_ready
res_ready  in  1  consumer accepts results
res_level  out  BOX_IDX  level the results belong to (clamped value)
sum1  out  S1_LEN  sum of box counts
sum2  out  S2_LEN  sum of squared box counts
nz_cnt  out  2*BOX_IDX+1  number of nonzero boxes

Behaviour:
- Reset RST, asynchronous, active-high; clock CLK. Reset values: state IDLE; rd_addr, busy, res_valid, res_level, sum1, sum2 and nz_cnt all 0.
- Reset mid-scan aborts the scan and discards partial sums. No result is produced.
- FSM states: IDLE, READ, DRAIN, HOLD.
- IDLE: start=1 latches the clamped level and clears all accumulators, then moves to READ. busy rises on the next cycle.
- READ: one address per cycle, M = side^2 addresses in total.
  - Scan order is row-major: y outer, x inner, both from 0 to side-1.
  - bank = 0 for level 0, bank = 1 for level >= 1.
  - Unused high bits of x and y are 0.
  - After the address with x = y = side-1 is issued, move to DRAIN.
- Pipeline: a 1-bit valid shadows each issued address by one cycle. On the edge where the shadow is 1:
  - sum1 += rd_data
  - sum2 += rd_data*rd_data (full 2*DATA_LEN product, zero-extended)
  - nz_cnt += (rd_data != 0)
- DRAIN: lasts one cycle and absorbs the last datum. Then move to HOLD: res_valid = 1, busy = 0.
- Latency: with the start edge as E0, addresses appear in cycles 1..M and res_valid is high from cycle M+2.
- HOLD:
  - res_valid and all result outputs stay stable while res_ready = 0.
  - res_ready = 1 completes the transfer. res_valid drops next cycle and the FSM returns to IDLE.
  - If start = 1 in the same cycle, the new scan is accepted directly: go to READ, accumulators cleared, results replaced.
- start while in READ or DRAIN is ignored.
- rd_addr returns to 0 outside READ. rd_data is ignored when the shadow valid is 0.
- Arithmetic is unsigned. No saturation is needed, because the widths cover 2^(2*BOX_IDX) maximum counts.

Decomposition:
- Shared package mfa_pkg:
  - BOX_IDX / DATA_LEN defaults
  - BC address field layout constants (BANK_BIT = BOX_IDX, X field [2*BOX_IDX:BOX_IDX+1], Y field [BOX_IDX-1:0])
  - FSM state enum
  - derived widths S1_LEN and S2_LEN
- One natural sub-module, bc_scan_addr: x/y counters, side/level clamp, address packing and last-address flag. The accumulate datapath and FSM stay in box_moment_acc.

Test Plan:
1. BOX_IDX=3, level=0, all 64 cells = 1 -> rd_addr covers bank 0 row-major; res_valid at cycle 66; sum1=64, sum2=64, nz_cnt=64, res_level=0.
2. level=1, 16 bank-1 cells all = 4 -> sum1=64, sum2=256, nz_cnt=16; res_valid at cycle 18.
3. level=2, cells (x,y) = (0,0):255, (1,0):0, (0,1):0, (1,1):3 -> rd_addr sequence 8, 24, 9, 25; sum1=258, sum2=65034, nz_cnt=2.
4. level=5 (out of range) -> clamped to 2; res_level=2; 4 reads.
5. Backpressure: res_ready low for 5 cycles in HOLD, start pulsed during READ -> results stable, that start ignored. res_ready=1 together with start (level=0) -> new scan begins next cycle with cleared sums.
6. RST asserted at cycle 10 of a level-0 scan -> all outputs 0 immediately, no res_valid. A following start produces correct fresh results.

Source files
------------

// File: rtl/mfa_pkg.sv
// Shared MFA definitions: default grid and count sizes, the BC memory address field
// layout, derived moment widths and the accumulator FSM state encoding.
package mfa_pkg;

  localparam int BOX_IDX  = 3;
  localparam int DATA_LEN = 8;

  localparam int ADDR_LEN = 2*BOX_IDX + 1;
  localparam int BANK_BIT = BOX_IDX;
  localparam int X_MSB    = 2*BOX_IDX;
  localparam int X_LSB    = BOX_IDX + 1;
  localparam int Y_MSB    = BOX_IDX - 1;
  localparam int Y_LSB    = 0;

  // Wide enough for 2^(2*BOX_IDX) maximal counts, so the sums never overflow.
  localparam int S1_LEN   = DATA_LEN + 2*BOX_IDX;
  localparam int S2_LEN   = 2*DATA_LEN + 2*BOX_IDX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } acc_state_e;

endpackage

// File: rtl/box_moment_acc_if.sv
// Request, BC-memory read port and result handshake of the box moment accumulator.
// slave is the accumulator side; master is the controller/memory side.
interface box_moment_acc_if #(
  parameter int BOX_IDX  = mfa_pkg::BOX_IDX,
  parameter int DATA_LEN = mfa_pkg::DATA_LEN
);
  logic                          start;
  logic [BOX_IDX-1:0]            level;
  logic [2*BOX_IDX:0]            rd_addr;
  logic [DATA_LEN-1:0]           rd_data;
  logic                          busy;
  logic                          res_valid;
  logic                          res_ready;
  logic [BOX_IDX-1:0]            res_level;
  logic [DATA_LEN+2*BOX_IDX-1:0] sum1;
  logic [2*DATA_LEN+2*BOX_IDX-1:0] sum2;
  logic [2*BOX_IDX:0]            nz_cnt;

  modport slave (
    input  start, level, rd_data, res_ready,
    output rd_addr, busy, res_valid, res_level, sum1, sum2, nz_cnt
  );

  modport master (
    output start, level, rd_data, res_ready,
    input  rd_addr, busy, res_valid, res_level, sum1, sum2, nz_cnt
  );
endinterface

// File: rtl/box_moment_acc_scan_addr.sv
// bc_scan_addr: walks one grid level of the BC memory row-major (y outer, x inner)
// and packs {x, bank, y}; also holds the clamped level of the current scan.
module bc_scan_addr
  import mfa_pkg::*;
#(
  parameter int BOX_IDX = mfa_pkg::BOX_IDX
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_i,
  input  logic [BOX_IDX-1:0] level_i,
  input  logic               step_i,
  output logic [2*BOX_IDX:0] addr_o,
  output logic               last_o,
  output logic [BOX_IDX-1:0] level_o
);

  localparam logic [BOX_IDX-1:0] LVL_MAX = BOX_IDX'(BOX_IDX-1);
  localparam logic [BOX_IDX-1:0] ONES    = '1;

  logic [BOX_IDX-1:0] level_q, level_d;
  logic [BOX_IDX-1:0] x_q, x_d;
  logic [BOX_IDX-1:0] y_q, y_d;
  logic [BOX_IDX-1:0] coord_max;
  logic               bank;

  // Highest coordinate is side-1 = 2^(BOX_IDX-level)-1.
  assign coord_max = ONES >> level_q;
  assign bank      = (level_q != '0);
  assign last_o    = (x_q == coord_max) && (y_q == coord_max);
  assign addr_o    = {x_q, bank, y_q};
  assign level_o   = level_q;

  always_comb begin
    level_d = level_q;
    x_d     = x_q;
    y_d     = y_q;
    if (load_i) begin
      level_d = (level_i > LVL_MAX) ? LVL_MAX : level_i;
      x_d     = '0;
      y_d     = '0;
    end else if (step_i) begin
      if (last_o) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == coord_max) begin
        x_d = '0;
        y_d = y_q + BOX_IDX'(1);
      end else begin
        x_d = x_q + BOX_IDX'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      level_q <= level_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: rtl/box_moment_acc.sv
// Scans one grid level of the box-count memory and accumulates sum n, sum n^2 and
// the nonzero-box count, then offers them on a valid/ready result handshake.
//   state | meaning
//   IDLE  | waiting for start
//   READ  | one BC address per cycle
//   DRAIN | last read datum in flight
//   HOLD  | results valid until res_ready
module box_moment_acc
  import mfa_pkg::*;
#(
  parameter int BOX_IDX  = mfa_pkg::BOX_IDX,
  parameter int DATA_LEN = mfa_pkg::DATA_LEN
) (
  input  logic             CLK,
  input  logic             RST,
  box_moment_acc_if.slave  bus
);

  localparam int A_LEN  = 2*BOX_IDX + 1;
  localparam int S1_W   = DATA_LEN + 2*BOX_IDX;
  localparam int S2_W   = 2*DATA_LEN + 2*BOX_IDX;
  localparam int SQ_W   = 2*DATA_LEN;

  acc_state_e         state_q, state_d;
  logic               vld_q;
  logic [S1_W-1:0]    sum1_q, sum1_d;
  logic [S2_W-1:0]    sum2_q, sum2_d;
  logic [A_LEN-1:0]   nz_q, nz_d;

  logic               load, step, last;
  logic               busy, res_valid;
  logic [A_LEN-1:0]   scan_addr, rd_addr;
  logic [BOX_IDX-1:0] lvl;
  logic [SQ_W-1:0]    rd_ext, rd_sq;

  bc_scan_addr #(.BOX_IDX(BOX_IDX)) u_scan (
    .CLK     (CLK),
    .RST     (RST),
    .load_i  (load),
    .level_i (bus.level),
    .step_i  (step),
    .addr_o  (scan_addr),
    .last_o  (last),
    .level_o (lvl)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    if (last) state_d = DRAIN;
      DRAIN:   state_d = HOLD;
      HOLD:    if (bus.res_ready) state_d = bus.start ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new scan can also be accepted on the result-handshake cycle.
  always_comb begin
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    rd_addr   = '0;
    unique case (state_q)
      IDLE:  load = bus.start;
      READ: begin
        step    = 1'b1;
        busy    = 1'b1;
        rd_addr = scan_addr;
      end
      DRAIN: busy = 1'b1;
      HOLD: begin
        res_valid = 1'b1;
        load      = bus.res_ready && bus.start;
      end
      default: ;
    endcase
  end

  assign rd_ext = SQ_W'(bus.rd_data);
  assign rd_sq  = rd_ext * rd_ext;

  always_comb begin
    sum1_d = sum1_q;
    sum2_d = sum2_q;
    nz_d   = nz_q;
    if (load) begin
      sum1_d = '0;
      sum2_d = '0;
      nz_d   = '0;
    end else if (vld_q) begin
      sum1_d = sum1_q + S1_W'(bus.rd_data);
      sum2_d = sum2_q + S2_W'(rd_sq);
      nz_d   = nz_q + A_LEN'(|bus.rd_data);
    end
  end

  // vld_q marks the cycle in which rd_data answers the previous READ address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q  <= 1'b0;
      sum1_q <= '0;
      sum2_q <= '0;
      nz_q   <= '0;
    end else begin
      vld_q  <= (state_q == READ);
      sum1_q <= sum1_d;
      sum2_q <= sum2_d;
      nz_q   <= nz_d;
    end
  end

  assign bus.rd_addr   = rd_addr;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid;
  assign bus.res_level = lvl;
  assign bus.sum1      = sum1_q;
  assign bus.sum2      = sum2_q;
  assign bus.nz_cnt    = nz_q;

endmodule

// File: tb/tb_box_moment_acc.sv
// Directed bench for box_moment_acc: stimulus pushes expected addresses and results
// into queues; a negedge monitor compares whatever the DUT presents.
module tb_box_moment_acc;
  import mfa_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  box_moment_acc_if bus ();

  box_moment_acc dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [DATA_LEN-1:0] mem [0:(1<<ADDR_LEN)-1];

  always @(posedge CLK) bus.rd_data <= mem[bus.rd_addr];

  typedef struct {
    int     lvl;
    int     m;
    longint s1;
    longint s2;
    longint nz;
  } exp_t;

  exp_t                 expq  [$];
  logic [ADDR_LEN-1:0]  addrq [$];

  int  n_pass  = 0;
  int  n_total = 0;
  int  pc      = 0;
  int  k_acc   = 0;
  bit  waiting = 1'b0;
  bit  rv_prev = 1'b0;
  bit  done    = 1'b0;
  bit  drained = 1'b0;

  always @(posedge CLK) pc <= pc + 1;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      chk("reset_outputs",
          longint'({bus.rd_addr, bus.busy, bus.res_valid, bus.res_level,
                    bus.sum1, bus.sum2, bus.nz_cnt}), 0);
      waiting = 1'b0;
      rv_prev = 1'b0;
    end else begin
      if (bus.busy && addrq.size() > 0)
        chk("rd_addr", longint'(bus.rd_addr), longint'(addrq.pop_front()));
      if (bus.res_valid) begin
        if (expq.size() == 0) begin
          chk("res_valid_without_request", longint'(bus.res_valid), 0);
        end else begin
          if (!rv_prev && waiting) begin
            chk("latency", longint'(pc - k_acc), longint'(expq[0].m + 2));
            waiting = 1'b0;
          end
          chk("res_level", longint'(bus.res_level), longint'(expq[0].lvl));
          chk("sum1",      longint'(bus.sum1),      expq[0].s1);
          chk("sum2",      longint'(bus.sum2),      expq[0].s2);
          chk("nz_cnt",    longint'(bus.nz_cnt),    expq[0].nz);
          if (bus.res_ready) void'(expq.pop_front());
        end
      end else if (waiting && (pc - k_acc) > 200) begin
        chk("result_timeout", longint'(bus.res_valid), 1);
        waiting = 1'b0;
      end
      if (bus.start && ((!bus.busy && !bus.res_valid) || (bus.res_valid && bus.res_ready))) begin
        k_acc   = pc;
        waiting = 1'b1;
      end
      rv_prev = bus.res_valid;
      if (done && !drained) begin
        chk("pending_results", longint'(expq.size()), 0);
        chk("pending_addrs",   longint'(addrq.size()), 0);
        drained = 1'b1;
      end
    end
  end

  function automatic logic [ADDR_LEN-1:0] mk_addr(input int x, input int y, input bit bank);
    logic [ADDR_LEN-1:0] a;
    a = '0;
    a[X_MSB:X_LSB] = BOX_IDX'(x);
    a[BANK_BIT]    = bank;
    a[Y_MSB:Y_LSB] = BOX_IDX'(y);
    return a;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic fill_all(input int v);
    for (int i = 0; i < (1<<ADDR_LEN); i++) mem[i] = DATA_LEN'(v);
  endtask

  task automatic set_cell(input int x, input int y, input bit bank, input int v);
    mem[mk_addr(x, y, bank)] = DATA_LEN'(v);
  endtask

  task automatic push_addrs(input int lvl_c);
    int side;
    side = 1 << (BOX_IDX - lvl_c);
    for (int y = 0; y < side; y++)
      for (int x = 0; x < side; x++)
        addrq.push_back(mk_addr(x, y, lvl_c != 0));
  endtask

  task automatic push_exp(input int lvl, input int m, input longint s1,
                          input longint s2, input longint nz);
    exp_t e;
    e.lvl = lvl; e.m = m; e.s1 = s1; e.s2 = s2; e.nz = nz;
    expq.push_back(e);
  endtask

  task automatic issue(input int lvl, input bit with_ready);
    bus.level     = BOX_IDX'(lvl);
    bus.start     = 1'b1;
    bus.res_ready = with_ready;
    tick(1);
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 300 && !bus.res_valid; i++) tick(1);
  endtask

  task automatic accept_after(input int stall);
    tick(stall);
    bus.res_ready = 1'b1;
    tick(1);
    bus.res_ready = 1'b0;
  endtask

  task automatic pattern_l0();
    fill_all(9);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) set_cell(x, y, 1'b0, 1);
  endtask

  task automatic pattern_l1();
    fill_all(7);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) set_cell(x, y, 1'b1, 4);
  endtask

  task automatic pattern_l2();
    fill_all(17);
    set_cell(0, 0, 1'b1, 255);
    set_cell(1, 0, 1'b1, 0);
    set_cell(0, 1, 1'b1, 0);
    set_cell(1, 1, 1'b1, 3);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.level     = '0;
    bus.res_ready = 1'b0;
    fill_all(0);
    tick(3);
    RST = 1'b0;
    tick(2);

    // level 0: all 64 bank-0 cells = 1
    pattern_l0();
    push_addrs(0);
    push_exp(0, 64, 64, 64, 64);
    issue(0, 1'b0);
    wait_valid();
    accept_after(2);
    tick(2);

    // level 1: 16 bank-1 cells = 4
    pattern_l1();
    push_addrs(1);
    push_exp(1, 16, 64, 256, 16);
    issue(1, 1'b0);
    wait_valid();
    accept_after(0);
    tick(2);

    // level 2: sparse cells, addresses 8, 24, 9, 25
    pattern_l2();
    addrq.push_back(7'd8);
    addrq.push_back(7'd24);
    addrq.push_back(7'd9);
    addrq.push_back(7'd25);
    push_exp(2, 4, 258, 65034, 2);
    issue(2, 1'b0);
    wait_valid();
    accept_after(1);
    tick(2);

    // level 5 clamps to 2
    push_addrs(2);
    push_exp(2, 4, 258, 65034, 2);
    issue(5, 1'b0);
    wait_valid();
    accept_after(0);
    tick(2);

    // backpressure, start ignored during READ, back-to-back restart on handshake
    pattern_l1();
    push_addrs(1);
    push_exp(1, 16, 64, 256, 16);
    issue(1, 1'b0);
    tick(4);
    issue(0, 1'b0);
    wait_valid();
    tick(5);
    push_addrs(0);
    push_exp(0, 64, 448, 3136, 64);
    issue(0, 1'b1);
    wait_valid();
    accept_after(0);
    tick(2);

    // reset in the middle of a level-0 scan, then a fresh scan
    pattern_l0();
    issue(0, 1'b0);
    tick(9);
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(2);
    pattern_l2();
    push_addrs(2);
    push_exp(2, 4, 258, 65034, 2);
    issue(2, 1'b0);
    wait_valid();
    accept_after(1);
    tick(3);

    done = 1'b1;
    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
